// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub.sv
// Combinational add/subtract used for the per-iteration partial product.
module addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s
);

  // sub=1 gives x-y (signed multiplier MSB weight is negative), else x+y
  assign s = sub ? (x - y) : (x + y);

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier, one multiplier bit per cycle, LSB first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | WIDTH iterations of add/subtract + shift, busy=1
// DONE  | product registered in m, done=1 for this single cycle
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] m,
  output logic               busy,
  output logic               done
);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_q;
  logic               sgn_q;
  logic [CNT_W-1:0]   cnt;
  // {upper half (WIDTH+1 bits), lower half}; the lower half starts as the
  // multiplier and fills with product bits as it shifts right
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_next;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     upper;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     partial;
  logic               last;
  logic               sub;
  logic               accept;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign a_ext  = {sgn_q & a_q[WIDTH-1], a_q};
  assign upper  = acc[2*WIDTH:WIDTH];
  assign sub    = sgn_q & last;

  addsub #(.W(WIDTH + 1)) u_addsub (
    .x   (upper),
    .y   (a_ext),
    .sub (sub),
    .s   (sum)
  );

  // one iteration: conditional add/subtract, then arithmetic or logical shift
  always_comb begin
    partial  = acc[0] ? sum : upper;
    acc_next = {sgn_q & partial[WIDTH], partial, acc[WIDTH-1:1]};
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // operand capture, iteration datapath and product register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      sgn_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      m     <= '0;
    end else if (accept) begin
      a_q   <= a;
      sgn_q <= is_signed;
      cnt   <= '0;
      acc   <= {{(WIDTH + 1){1'b0}}, b};
    end else if (state == CALC) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      if (last) m <= acc_next[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: timeline/product model for an 8-bit and a 16-bit DUT.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] m8;
  logic        busy8, done8;
  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic [31:0] m16;
  logic        busy16, done16;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .m(m8), .busy(busy8), .done(done8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(sgn16),
    .a(a16), .b(b16), .m(m16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // exact product of w-bit operands, truncated to 2w bits
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s, input int w);
    longint xv, yv, p;
    logic [63:0] mask;
    xv = longint'({32'd0, x});
    yv = longint'({32'd0, y});
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    p    = xv * yv;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // timeline model: accept in idle, WIDTH busy cycles, one done cycle
  int rem8, rem16;
  bit edone8, edone16;
  logic [15:0] em8, pend8;
  logic [31:0] em16, pend16;

  always @(posedge clk) begin
    if (rst) begin
      rem8 = 0; edone8 = 0; em8 = '0;
    end else if (rem8 > 0) begin
      rem8--;
      if (rem8 == 0) begin em8 = pend8; edone8 = 1; end
    end else if (edone8) edone8 = 0;
    else if (start8) begin
      rem8  = 8;
      pend8 = 16'(ref_prod({24'd0, a8}, {24'd0, b8}, sgn8, 8));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      rem16 = 0; edone16 = 0; em16 = '0;
    end else if (rem16 > 0) begin
      rem16--;
      if (rem16 == 0) begin em16 = pend16; edone16 = 1; end
    end else if (edone16) edone16 = 0;
    else if (start16) begin
      rem16  = 16;
      pend16 = 32'(ref_prod({16'd0, a16}, {16'd0, b16}, sgn16, 16));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8",  64'(busy8),  64'(rem8 > 0));
      chk("done8",  64'(done8),  64'(edone8));
      chk("m8",     64'(m8),     64'(em8));
      chk("busy16", 64'(busy16), 64'(rem16 > 0));
      chk("done16", 64'(done16), 64'(edone16));
      chk("m16",    64'(m16),    64'(em16));
    end
  end

  task automatic wait_done8(inout int n);
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                      input logic [15:0] texp, input string nm);
    int n;
    a8 = ta; b8 = tb_; sgn8 = ts; start8 = 1;
    @(posedge clk); #1;
    start8 = 0; n = 0;
    wait_done8(n);
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk(nm, 64'(m8), 64'(texp));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, pulses, guard, last_done, n_done;

    vecs[0] = '{8'd5,   8'd5,   1'b0, 16'h0019, "u_5x5"};
    vecs[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, "u_255x255"};
    vecs[2] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1, "s_m3x5"};
    vecs[3] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s_minxmin"};
    vecs[4] = '{8'h80,  8'h7F,  1'b1, 16'hC080, "s_minxmax"};
    vecs[5] = '{8'h00,  8'hFF,  1'b1, 16'h0000, "s_zero"};
    vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, "s_m1xm1"};
    vecs[7] = '{8'h7F,  8'h80,  1'b0, 16'h3F80, "u_127x128"};

    chk("ref_u_5x5",     ref_prod(32'd5,    32'd5,    1'b0, 8),  64'h0019);
    chk("ref_s_m3x5",    ref_prod(32'hFD,   32'h05,   1'b1, 8),  64'hFFF1);
    chk("ref_s_minxmax", ref_prod(32'h80,   32'h7F,   1'b1, 8),  64'hC080);
    chk("ref_s16_m1x2",  ref_prod(32'hFFFF, 32'h0002, 1'b1, 16), 64'hFFFF_FFFE);

    rst = 1; start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
    start16 = 0; sgn16 = 0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1;
    chk("reset_m8", 64'(m8), 64'd0);
    chk("reset_busy8", 64'(busy8), 64'd0);
    rst = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].nm);

    // restart attempt with new operands during CALC must be ignored
    a8 = 8'd3; b8 = 8'd7; sgn8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0; n = 0;
    repeat (2) begin @(posedge clk); #1; n++; end
    a8 = 8'd9; b8 = 8'd9; sgn8 = 1; start8 = 1;
    @(posedge clk); #1; n++;
    start8 = 0;
    wait_done8(n);
    chk("ignore_restart_latency", 64'(n), 64'd8);
    chk("ignore_restart_m", 64'(m8), 64'h0015);
    @(posedge clk); #1;

    // reset on the 4th CALC edge abandons the operation
    a8 = 8'd10; b8 = 8'd10; sgn8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_m", 64'(m8), 64'd0);
    pulses = 0;
    repeat (15) begin @(posedge clk); #1; if (done8) pulses++; end
    chk("abort_no_done", 64'(pulses), 64'd0);

    // start already present in the first cycle after reset release
    rst = 1; a8 = 8'd6; b8 = 8'd7; sgn8 = 1; start8 = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    start8 = 0; n = 0;
    wait_done8(n);
    chk("post_reset_latency", 64'(n), 64'd8);
    chk("post_reset_m", 64'(m8), 64'h002A);
    @(posedge clk); #1;

    // 16-bit back-to-back random operations with start held high
    start16 = 1; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
    n_done = 0; guard = 0; last_done = 0;
    while (n_done < 200 && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      if (done16) begin
        if (n_done > 0) chk("done16_spacing", 64'(guard - last_done), 64'd18);
        last_done = guard;
        n_done++;
      end
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
    end
    chk("done16_count", 64'(n_done), 64'd200);
    start16 = 0;
    repeat (20) @(posedge clk);
    #1 chk_en = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width (legal range 4..32).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 Port is_signed, input, 1 bit: 1 means two's-complement operands, 0 means unsigned; latched with the operands.
REQ-007 Port a, input, WIDTH bits: the multiplicand.
REQ-008 Port b, input, WIDTH bits: the multiplier.
REQ-009 Port m, output, 2*WIDTH bits: the registered product.
REQ-010 Port busy, output, 1 bit: high while an operation is in progress.
REQ-011 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 at edge t SHALL latch a, b and is_signed, clear the accumulator and counter, and enter CALC.
REQ-014 CALC SHALL process one multiplier bit per cycle, LSB first, for exactly WIDTH cycles (edges t+1..t+WIDTH).
REQ-015 Per iteration, bit=1 SHALL add the sign/zero-extended multiplicand to the upper accumulator half, then shift right arithmetically (signed) or logically (unsigned).
REQ-016 In signed mode, the partial product of multiplier bit WIDTH-1 SHALL be subtracted instead of added.
REQ-017 The accumulator SHALL be 2*WIDTH+1 bits wide so that no intermediate overflow occurs.
REQ-018 At edge t+WIDTH the FSM SHALL enter DONE, load m with the exact 2*WIDTH-bit product, and assert done.
REQ-019 done SHALL be high for exactly one cycle; the next edge SHALL clear done and return the FSM to IDLE.
REQ-020 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-021 m SHALL hold its value until the next completion; it SHALL NOT change during CALC.
REQ-022 start SHALL be ignored in CALC and DONE; operand changes in those states SHALL have no effect.
REQ-023 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle after DONE, giving one result per WIDTH+2 cycles.
REQ-024 Operands 0 and boundary values (all ones, most-negative) SHALL produce exact results with no special-case latency.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE and set m=0, busy=0, done=0, and counter=0, overriding start.
REQ-026 Reset during CALC SHALL abandon the operation with no done pulse.
REQ-027 A start request present in the first cycle after reset is released SHALL be accepted normally.

Structure
REQ-028 The FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) SHALL live in the shared package mult_pkg.
REQ-029 The (WIDTH+1)-bit add/subtract SHALL be a sub-module addsub, parameterised by width, with a sub control input.
REQ-030 All other logic SHALL reside in seq_multiplier.

Verification
REQ-031 With WIDTH=8, unsigned, a=5, b=5, start for one cycle -> busy for 8 cycles, done at edge t+8, m=16'h0019.
REQ-032 With WIDTH=8, unsigned, a=255, b=255 -> m=16'hFE01; signed, a=-3 (8'hFD), b=5 -> m=16'hFFF1.
REQ-033 With WIDTH=8, signed, a=b=8'h80 -> m=16'h4000; signed, a=8'h80, b=8'h7F -> m=16'hC080.
REQ-034 start re-pulsed with new operands during CALC -> ignored; the result matches the first operands; m is stable during CALC.
REQ-035 rst asserted at the 4th CALC cycle -> next cycle busy=0, done=0, m=0, and no done pulse follows.
REQ-036 With WIDTH=16, 200 random signed/unsigned operations with start held high -> each m equals the reference product, done spacing is 18 cycles.
